// File: rtl/seq_mul_pkg.sv
// -----------------------------------------------------------------------------
// seq_mul_pkg
// Shared definitions for the sequential shift-and-add multiplier.
//   state_t     : FSM state encoding (IDLE=0, LOAD=1, CALC=2, DONE=3)
//   W_DEFAULT   : default operand width
//   LMT_DEFAULT : default final count of the external iteration counter
//                 (must equal W_DEFAULT-1 so that exactly W steps happen)
// -----------------------------------------------------------------------------
package seq_mul_pkg;

   localparam int         W_DEFAULT   = 4;
   localparam logic [1:0] LMT_DEFAULT = 2'b11;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      LOAD = 2'd1,
      CALC = 2'd2,
      DONE = 2'd3
   } state_t;

endpackage

// File: rtl/cnt4.sv
// -----------------------------------------------------------------------------
// cnt4
// Small 2-bit iteration counter that lives next to the multiplier controller.
// It is wired up at the parent level through the controller's cnt_* ports.
//   clk, reset_n : clock, asynchronous active-low reset
//   load, data   : synchronous load of the counter value
//   en           : increment enable (wraps modulo 4)
//   lmt          : terminal value
//   out          : current counter value
//   tc           : registered terminal count, high the cycle after out==lmt
// -----------------------------------------------------------------------------
module cnt4 (
   input  logic       clk,
   input  logic       reset_n,
   input  logic       load,
   input  logic       en,
   input  logic [1:0] data,
   input  logic [1:0] lmt,
   output logic [1:0] out,
   output logic       tc
);

   // The terminal count is a registered compare of the current value, so it
   // always lags the counter by one cycle; load takes priority over counting.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         out <= 2'd0;
         tc  <= 1'b0;
      end else begin
         tc <= (out == lmt);
         if (load) begin
            out <= data;
         end else if (en) begin
            out <= out + 2'd1;
         end
      end
   end

endmodule

// File: rtl/seq_mul_dp.sv
// -----------------------------------------------------------------------------
// seq_mul_dp
// Datapath of the shift-and-add multiplier: multiplicand register A, the
// 2*W-bit partial product P (hi half accumulates, lo half holds the
// remaining multiplier bits) and the carry that enters P at its MSB.
//   clk, reset_n : clock, asynchronous active-low reset
//   ld_i         : capture a_i into A and b_i into lo(P)
//   clr_i        : clear hi(P) and the carry
//   step_i       : one conditional add + right shift
//   a_i, b_i     : operands
//   product_o    : the full P register {carry, rest of P}
// -----------------------------------------------------------------------------
module seq_mul_dp
   import seq_mul_pkg::*;
#(
   parameter int W = W_DEFAULT
) (
   input  logic           clk,
   input  logic           reset_n,
   input  logic           ld_i,
   input  logic           clr_i,
   input  logic           step_i,
   input  logic [W-1:0]   a_i,
   input  logic [W-1:0]   b_i,
   output logic [2*W-1:0] product_o
);

   logic [W-1:0]   a_q, a_d;
   logic [2*W-2:0] p_q, p_d;
   logic           carry_q, carry_d;
   logic [W-1:0]   hi;
   logic [W-1:0]   lo;
   logic [W:0]     sum;

   // The carry register doubles as the MSB of P: after every shift the adder
   // carry lands there, so hi(P) is {carry, upper bits of p_q}. A step adds A
   // into hi when the current multiplier bit (P[0]) is set, then shifts the
   // whole {carry, hi, lo} right by one.
   always_comb begin
      hi      = {carry_q, p_q[2*W-2:W]};
      lo      = p_q[W-1:0];
      sum     = lo[0] ? ({1'b0, hi} + {1'b0, a_q}) : {1'b0, hi};
      a_d     = a_q;
      p_d     = p_q;
      carry_d = carry_q;
      if (clr_i) begin
         carry_d        = 1'b0;
         p_d[2*W-2:W]   = '0;
      end
      if (ld_i) begin
         a_d            = a_i;
         p_d[W-1:0]     = b_i;
      end
      if (step_i) begin
         carry_d        = sum[W];
         p_d            = {sum[W-1:0], lo[W-1:1]};
      end
   end

   // Plain register bank; everything clears on reset so an aborted operation
   // leaves a zero product behind.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         a_q     <= '0;
         p_q     <= '0;
         carry_q <= 1'b0;
      end else begin
         a_q     <= a_d;
         p_q     <= p_d;
         carry_q <= carry_d;
      end
   end

   assign product_o = {carry_q, p_q};

endmodule

// File: rtl/seq_mul_ctrl.sv
// -----------------------------------------------------------------------------
// seq_mul_ctrl
// Controller for a W x W unsigned sequential multiplier. Iterations are
// timed by an external cnt4 counter driven through the cnt_* ports.
//   clk, reset_n       : clock, asynchronous active-low reset
//   start              : request, only looked at in IDLE
//   a, b               : operands, captured when start is accepted
//   product            : 2*W-bit result, valid with done, held until next accept
//   busy               : high in LOAD, CALC and DONE
//   done               : one-cycle pulse in DONE
//   cnt_load, cnt_en   : load strobe / count enable for cnt4
//   cnt_data, cnt_lmt  : constant load value (0) and terminal value (LMT)
//   cnt_tc             : registered terminal count back from cnt4
// LMT must equal W-1 so that the counter runs exactly W steps.
// -----------------------------------------------------------------------------
module seq_mul_ctrl
   import seq_mul_pkg::*;
#(
   parameter int         W   = W_DEFAULT,
   parameter logic [1:0] LMT = LMT_DEFAULT
) (
   input  logic           clk,
   input  logic           reset_n,
   input  logic           start,
   input  logic [W-1:0]   a,
   input  logic [W-1:0]   b,
   output logic [2*W-1:0] product,
   output logic           busy,
   output logic           done,
   output logic           cnt_load,
   output logic           cnt_en,
   output logic [1:0]     cnt_data,
   output logic [1:0]     cnt_lmt,
   input  logic           cnt_tc
);

   state_t state_q, state_d;
   logic   firstCycle_q, firstCycle_d;
   logic   accept;
   logic   stepEn;

   // State and first-CALC-cycle flag. The flag exists because cnt_tc is a
   // registered signal: in the first CALC cycle it still reflects the counter
   // value from before the load and must not be trusted.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q      <= IDLE;
         firstCycle_q <= 1'b0;
      end else begin
         state_q      <= state_d;
         firstCycle_q <= firstCycle_d;
      end
   end

   // Next-state logic. CALC exits only once a fresh terminal count arrives;
   // DONE always returns to IDLE so a held start is only seen one cycle later.
   always_comb begin
      state_d      = state_q;
      firstCycle_d = firstCycle_q;
      case (state_q)
         IDLE: begin
            if (start) begin
               state_d = LOAD;
            end
         end
         LOAD: begin
            state_d      = CALC;
            firstCycle_d = 1'b1;
         end
         CALC: begin
            firstCycle_d = 1'b0;
            if (!firstCycle_q && cnt_tc) begin
               state_d = DONE;
            end
         end
         DONE: begin
            state_d = IDLE;
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   // Output decode. A datapath step happens exactly when the counter is
   // enabled, which keeps the step count locked to the counter. Load and
   // enable are decoded from different states and so never overlap.
   always_comb begin
      busy     = (state_q != IDLE);
      done     = (state_q == DONE);
      cnt_load = (state_q == LOAD);
      cnt_en   = (state_q == CALC) && (firstCycle_q || !cnt_tc);
      accept   = (state_q == IDLE) && start;
      stepEn   = cnt_en;
   end

   assign cnt_data = 2'b00;
   assign cnt_lmt  = LMT;

   seq_mul_dp #(
      .W (W)
   ) u_dp (
      .clk       (clk),
      .reset_n   (reset_n),
      .ld_i      (accept),
      .clr_i     (accept),
      .step_i    (stepEn),
      .a_i       (a),
      .b_i       (b),
      .product_o (product)
   );

endmodule

// File: tb/tb_seq_mul_ctrl.sv
// -----------------------------------------------------------------------------
// tb_seq_mul_ctrl
// Bench for seq_mul_ctrl with a real cnt4 attached through the cnt_* ports.
// The bench can override the counter's load/data to preload it before an
// operation. Expected products come from plain multiplication.
// -----------------------------------------------------------------------------
module tb_seq_mul_ctrl;

   localparam int W = 4;

   typedef struct {
      logic [W-1:0]   a;
      logic [W-1:0]   b;
      logic [2*W-1:0] prod;
   } vec_t;

   logic           clk = 1'b0;
   logic           reset_n;
   logic           start;
   logic [W-1:0]   a;
   logic [W-1:0]   b;
   logic [2*W-1:0] product;
   logic           busy;
   logic           done;
   logic           cntLoad;
   logic           cntEn;
   logic [1:0]     cntData;
   logic [1:0]     cntLmt;
   logic           cntTc;
   logic [1:0]     cntOut;
   logic           tbCntLoad;
   logic [1:0]     tbCntData;
   logic           cntLoadMux;
   logic [1:0]     cntDataMux;

   int compared   = 0;
   int mismatched = 0;

   vec_t vecs[8];

   // Free-running 100 MHz clock.
   always #5 clk = ~clk;

   seq_mul_ctrl #(
      .W   (W),
      .LMT (2'b11)
   ) dut (
      .clk      (clk),
      .reset_n  (reset_n),
      .start    (start),
      .a        (a),
      .b        (b),
      .product  (product),
      .busy     (busy),
      .done     (done),
      .cnt_load (cntLoad),
      .cnt_en   (cntEn),
      .cnt_data (cntData),
      .cnt_lmt  (cntLmt),
      .cnt_tc   (cntTc)
   );

   // The bench may take over the counter's load port to preload a value.
   assign cntLoadMux = cntLoad | tbCntLoad;
   assign cntDataMux = tbCntLoad ? tbCntData : cntData;

   cnt4 u_cnt (
      .clk     (clk),
      .reset_n (reset_n),
      .load    (cntLoadMux),
      .en      (cntEn),
      .data    (cntDataMux),
      .lmt     (cntLmt),
      .out     (cntOut),
      .tc      (cntTc)
   );

   // Counter load and enable must never be high together.
   always @(negedge clk) begin
      if (reset_n) begin
         compared++;
         if (cntLoad && cntEn) begin
            mismatched++;
            $display("[TB] FAIL load_en_overlap: cnt_load=%0b cnt_en=%0b, required not both 1", cntLoad, cntEn);
         end
      end
   end

   // Hard stop in case something never finishes.
   initial begin
      #200000;
      $display("[TB] FAIL watchdog: simulation time limit reached");
      $fatal(1, "[TB] watchdog");
   end

   function automatic logic [2*W-1:0] refProduct(input logic [W-1:0] av, input logic [W-1:0] bv);
      return (2*W)'(int'(av) * int'(bv));
   endfunction

   task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
      compared++;
      if (actual !== expected) begin
         mismatched++;
         $display("[TB] FAIL %s: got %0h, want %0h", name, actual, expected);
      end
   endtask

   // Runs one full operation starting at a negedge: start is applied for one
   // cycle, operands are scrambled right after accept, and the cycle-by-cycle
   // handshake is compared against the expected 7-cycle schedule
   // (LOAD in cycle 1, counting in cycles 2-5, done in cycle 7).
   task automatic applyStimulus(input logic [W-1:0] av, input logic [W-1:0] bv,
                                input logic [2*W-1:0] expProd, input string tag);
      int   lat;
      int   busyCycles;
      logic seenDone;
      a     = av;
      b     = bv;
      start = 1'b1;
      @(negedge clk);
      start      = 1'b0;
      a          = 4'($urandom);
      b          = 4'($urandom);
      lat        = 1;
      busyCycles = 0;
      seenDone   = 1'b0;
      while (!seenDone && lat <= 20) begin
         if (busy) busyCycles++;
         checkOutput({tag, " cnt_load"}, 32'(cntLoad), 32'(lat == 1));
         checkOutput({tag, " cnt_en"}, 32'(cntEn), 32'(lat >= 2 && lat <= 5));
         if (done) begin
            seenDone = 1'b1;
         end else begin
            @(negedge clk);
            lat++;
         end
      end
      checkOutput({tag, " latency"}, 32'(lat), 32'd7);
      checkOutput({tag, " busy cycles"}, 32'(busyCycles), 32'd7);
      checkOutput({tag, " product"}, 32'(product), 32'(expProd));
      @(negedge clk);
      checkOutput({tag, " done pulse width"}, 32'(done), 32'd0);
      checkOutput({tag, " busy after done"}, 32'(busy), 32'd0);
      checkOutput({tag, " product hold"}, 32'(product), 32'(expProd));
   endtask

   initial begin
      int cyc;
      logic [W-1:0] ra;
      logic [W-1:0] rb;

      vecs[0] = '{4'd3,  4'd5,  8'h0F};
      vecs[1] = '{4'd15, 4'd15, 8'hE1};
      vecs[2] = '{4'd0,  4'd9,  8'h00};
      vecs[3] = '{4'd9,  4'd0,  8'h00};
      vecs[4] = '{4'd15, 4'd1,  8'h0F};
      vecs[5] = '{4'd7,  4'd8,  8'h38};
      vecs[6] = '{4'd10, 4'd11, 8'h6E};
      vecs[7] = '{4'd12, 4'd13, 8'h9C};

      reset_n   = 1'b0;
      start     = 1'b0;
      a         = '0;
      b         = '0;
      tbCntLoad = 1'b0;
      tbCntData = 2'd0;

      #12;
      checkOutput("reset busy", 32'(busy), 32'd0);
      checkOutput("reset done", 32'(done), 32'd0);
      checkOutput("reset product", 32'(product), 32'd0);
      checkOutput("reset cnt_load", 32'(cntLoad), 32'd0);
      checkOutput("reset cnt_en", 32'(cntEn), 32'd0);
      checkOutput("cnt_data const", 32'(cntData), 32'd0);
      checkOutput("cnt_lmt const", 32'(cntLmt), 32'd3);

      // Release reset and start in the same cycle: the first edge must accept.
      @(negedge clk);
      reset_n = 1'b1;
      for (int i = 0; i < 8; i++) begin
         applyStimulus(vecs[i].a, vecs[i].b, vecs[i].prod, $sformatf("vec%0d", i));
      end

      // Start held high: second accept waits for the first IDLE after DONE,
      // and operand changes during the first op must not matter.
      a     = 4'd9;
      b     = 4'd7;
      start = 1'b1;
      @(negedge clk);
      a   = 4'd2;
      b   = 4'd6;
      cyc = 1;
      while (!done && cyc < 20) begin
         @(negedge clk);
         cyc++;
      end
      checkOutput("b2b first latency", 32'(cyc), 32'd7);
      checkOutput("b2b first product", 32'(product), 32'h3F);
      cyc = 0;
      do begin
         @(negedge clk);
         cyc++;
         if (cyc == 1) checkOutput("b2b idle gap busy", 32'(busy), 32'd0);
         if (cyc == 2) start = 1'b0;
      end while (!done && cyc < 20);
      checkOutput("b2b done spacing", 32'(cyc), 32'd8);
      checkOutput("b2b second product", 32'(product), 32'h0C);
      @(negedge clk);

      // Start pulses during CALC with other operands are ignored.
      a     = 4'd6;
      b     = 4'd7;
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      cyc   = 1;
      while (!done && cyc < 20) begin
         @(negedge clk);
         cyc++;
         start = (cyc == 3 || cyc == 5);
         if (start) begin
            a = 4'd15;
            b = 4'd15;
         end
      end
      start = 1'b0;
      checkOutput("ignore latency", 32'(cyc), 32'd7);
      checkOutput("ignore product", 32'(product), 32'h2A);
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         checkOutput("ignore no queued op", 32'(busy), 32'd0);
      end

      // Reset in the fourth CALC cycle aborts everything immediately.
      a     = 4'd5;
      b     = 4'd5;
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      repeat (4) @(negedge clk);
      checkOutput("abort busy before reset", 32'(busy), 32'd1);
      reset_n = 1'b0;
      #1;
      checkOutput("abort busy", 32'(busy), 32'd0);
      checkOutput("abort done", 32'(done), 32'd0);
      checkOutput("abort cnt_load", 32'(cntLoad), 32'd0);
      checkOutput("abort cnt_en", 32'(cntEn), 32'd0);
      checkOutput("abort product", 32'(product), 32'd0);
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         checkOutput("abort no done", 32'(done), 32'd0);
      end
      reset_n = 1'b1;
      applyStimulus(4'd4, 4'd4, 8'h10, "after abort");

      // Preload the counter so its terminal count is stale-high when CALC
      // begins; the operation must still take four steps.
      tbCntLoad = 1'b1;
      tbCntData = 2'd3;
      @(negedge clk);
      tbCntLoad = 1'b0;
      checkOutput("preload value", 32'(cntOut), 32'd3);
      @(negedge clk);
      checkOutput("preload tc high", 32'(cntTc), 32'd1);
      applyStimulus(4'd6, 4'd5, 8'h1E, "stale tc");

      // Random operands with random idle gaps against plain multiplication.
      for (int i = 0; i < 20; i++) begin
         ra = 4'($urandom_range(0, 15));
         rb = 4'($urandom_range(0, 15));
         repeat ($urandom_range(0, 2)) @(negedge clk);
         applyStimulus(ra, rb, refProduct(ra, rb), $sformatf("rand%0d", i));
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

endmodule
